// File: rtl/intr_controller_if.sv
// Purpose: bundles the interrupt source, mask, CPU handshake and status signals of intr_controller.
// Latency: none, this is only a signal bundle.
// Backpressure: intr_req stays high until intr_ack; each service is closed by an eoi pulse.
interface intr_controller_if #(
    parameter int N_SRC = 4,
    parameter int VEC_W = 2
);
    // Source and CPU side inputs to the controller
    logic [N_SRC-1:0] irq_in;
    logic             mask_wr;
    logic [N_SRC-1:0] mask_in;
    logic             intr_ack;
    logic             eoi;

    // Controller outputs, all registered
    logic             intr_req;
    logic [VEC_W-1:0] intr_vec;
    logic [N_SRC-1:0] pending;
    logic             busy;
    logic             timeout_flag;

    // The controller owns the request/status side
    modport master (
        input  irq_in, mask_wr, mask_in, intr_ack, eoi,
        output intr_req, intr_vec, pending, busy, timeout_flag
    );

    // Sources, mask writer and CPU drive the inputs and observe status
    modport slave (
        output irq_in, mask_wr, mask_in, intr_ack, eoi,
        input  intr_req, intr_vec, pending, busy, timeout_flag
    );
endinterface

// File: rtl/intr_controller.sv
// Purpose: prioritised interrupt controller. Edge-detects and latches requests, masks them, and
//          hands the lowest enabled index to the CPU one at a time (req/ack, then eoi).
// Latency: irq edge -> pending 1 cycle, pending -> intr_req 1 more cycle; eoi -> next req 1 cycle.
// Backpressure: intr_req held until intr_ack; no new request until eoi. Optional macro
//          INTR_TIMEOUT_EN adds an ack-wait timeout with a sticky timeout_flag.
module intr_controller #(
    parameter int N_SRC = 4,
    parameter int VEC_W = 2     // must equal $clog2(N_SRC)
`ifdef INTR_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 64  // REQ cycles allowed before the request is withdrawn
`endif
) (
    input logic               sys_clk,
    input logic               reset,
    intr_controller_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_SRC-1:0] irq_q, irq_d;          // previous-cycle irq_in levels
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic             req_q, req_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic             busy_q, busy_d;

    logic [N_SRC-1:0] irq_edge;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] ack_clr;
    logic [VEC_W-1:0] lowest_idx;
    logic             any_eligible;

`ifdef INTR_TIMEOUT_EN
    // Counter is at least 8 bits and wide enough to hold TIMEOUT
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tflag_q, tflag_d;
`endif

    // Rising-edge detect, mask register load, and pending-bit set/clear (set wins)
    always_comb begin
        irq_d        = bus.irq_in;
        irq_edge     = bus.irq_in & ~irq_q;
        mask_d       = bus.mask_wr ? bus.mask_in : mask_q;
        pending_d    = (pending_q & ~ack_clr) | irq_edge;
        eligible     = pending_q & mask_q;
        any_eligible = |eligible;
    end

    // Priority encoder: index 0 wins, so scan from the top and let lower hits overwrite
    always_comb begin
        lowest_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                lowest_idx = VEC_W'(i);
            end
        end
    end

    // Next-state and registered-output logic of the request/service FSM
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        vec_d   = vec_q;
        busy_d  = busy_q;
        ack_clr = '0;
`ifdef INTR_TIMEOUT_EN
        cnt_d   = cnt_q;
        tflag_d = tflag_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // intr_ack here is ignored; only pending & mask starts a request
                if (any_eligible) begin
                    vec_d   = lowest_idx;
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_REQ;
`ifdef INTR_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_REQ: begin
                // eoi is ignored while the CPU has not yet acknowledged
                if (bus.intr_ack) begin
                    ack_clr[vec_q] = 1'b1;
                    req_d          = 1'b0;
                    state_d        = ST_SERVICE;
                end
`ifdef INTR_TIMEOUT_EN
                // Withdraw the request but keep it pending so it is re-raised next cycle
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    tflag_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_SERVICE: begin
                // vec held for the ISR; new edges keep latching into pending meanwhile
                if (bus.eoi) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            irq_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            req_q     <= 1'b0;
            vec_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            req_q     <= req_d;
            vec_q     <= vec_d;
            busy_q    <= busy_d;
        end
    end

`ifdef INTR_TIMEOUT_EN
    // Ack-wait counter and sticky timeout flag
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            cnt_q   <= '0;
            tflag_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            tflag_q <= tflag_d;
        end
    end

    assign bus.timeout_flag = tflag_q;
`else
    assign bus.timeout_flag = 1'b0;
`endif

    assign bus.intr_req = req_q;
    assign bus.intr_vec = vec_q;
    assign bus.pending  = pending_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_intr_controller.sv
// Purpose: randomized self-checking bench for intr_controller with a scoreboard of expected requests.
// Latency: checks the 2-cycle irq->req and 1-cycle eoi->req timing.
// Backpressure: the bench plays the CPU, delaying ack and issuing eoi at random.
module tb_intr_controller;
    localparam int N_SRC = 4;
    localparam int VEC_W = 2;
`ifdef INTR_TIMEOUT_EN
    localparam int TMO = 8;
`endif

    logic sys_clk = 1'b0;
    logic reset;

    intr_controller_if #(.N_SRC(N_SRC), .VEC_W(VEC_W)) bus ();

`ifdef INTR_TIMEOUT_EN
    intr_controller #(.N_SRC(N_SRC), .VEC_W(VEC_W), .TIMEOUT(TMO)) dut (
        .sys_clk(sys_clk), .reset(reset), .bus(bus));
`else
    intr_controller #(.N_SRC(N_SRC), .VEC_W(VEC_W)) dut (
        .sys_clk(sys_clk), .reset(reset), .bus(bus));
`endif

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [31:0] vec;
        logic [31:0] pend;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: set of pending sources, enable mask, sticky timeout
    int   m_pend = 0;
    int   m_mask = 0;
    int   m_flag = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Highest-priority (lowest index) member of a set, -1 when empty
    function automatic int lowest(input int bits);
        for (int i = 0; i < N_SRC; i++) begin
            if (bits[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit eligible();
        return (m_pend & m_mask) != 0;
    endfunction

    task automatic tick();
        @(negedge sys_clk);
    endtask

    task automatic push_expected();
        exp_t e;
        e.vec  = lowest(m_pend & m_mask);
        e.pend = m_pend;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every new request must match the oldest expected one
    logic prev_req = 1'b0;
    always @(negedge sys_clk) begin
        exp_t e;
        if (reset) begin
            prev_req = 1'b0;
        end else begin
            if (bus.intr_req === 1'b1 && prev_req == 1'b0) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_req: got vec %0d with no request expected at %0t",
                             bus.intr_vec, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("req_vec", 32'(bus.intr_vec), e.vec);
                    check("req_pending", 32'(bus.pending), e.pend);
                end
            end
            prev_req = bus.intr_req;
        end
    end

    // Wait for intr_req, checking the exact number of cycles it took
    task automatic wait_req(input int exp_cyc, input string name, output bit ok);
        int n;
        n = 0;
        while (bus.intr_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(name, n, exp_cyc);
        ok = (bus.intr_req === 1'b1);
    endtask

    task automatic apply_reset_check(input string tag);
        check({tag, "_req"},     32'(bus.intr_req), 0);
        check({tag, "_vec"},     32'(bus.intr_vec), 0);
        check({tag, "_pending"}, 32'(bus.pending), 0);
        check({tag, "_busy"},    32'(bus.busy), 0);
        check({tag, "_tflag"},   32'(bus.timeout_flag), 0);
    endtask

    // One request/service, entered at the negedge where intr_req is first visible
    task automatic serve(output bit stop);
        int v;
        int d;
        int inj;
        int nm;
        bit ok;
        stop = 1'b0;
        v = lowest(m_pend & m_mask);
`ifdef INTR_TIMEOUT_EN
        if ($urandom_range(0, 4) == 0) begin
            push_expected();
            repeat (TMO - 1) tick();
            check("req_before_timeout", 32'(bus.intr_req), 1);
            tick();
            check("req_after_timeout", 32'(bus.intr_req), 0);
            m_flag = 1;
            check("timeout_flag", 32'(bus.timeout_flag), 1);
            wait_req(1, "rereq_latency", ok);
            if (!ok) begin
                stop = 1'b1;
                return;
            end
        end
`endif
        // Random ack delay, with eoi pulses that REQ must ignore
        d = $urandom_range(0, 3);
        repeat (d) begin
            bus.eoi = 1'($urandom_range(0, 1));
            tick();
        end
        bus.eoi = 1'b0;
        check("req_held", 32'(bus.intr_req), 1);

        // Acknowledge, sometimes with a coinciding new edge (set wins over clear)
        inj = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : 0;
        bus.intr_ack = 1'b1;
        bus.irq_in   = N_SRC'(inj);
        tick();
        bus.intr_ack = 1'b0;
        bus.irq_in   = '0;
        m_pend = (m_pend & ~(1 << v)) | inj;
        check("ack_req_low", 32'(bus.intr_req), 0);
        check("ack_busy", 32'(bus.busy), 1);
        check("ack_pending", 32'(bus.pending), m_pend);

        // Mid-service reset with a fresh edge on the serviced source: everything is lost
        if ($urandom_range(0, 11) == 0) begin
            bus.irq_in = N_SRC'(1 << v);
            reset = 1'b1;
            tick();
            apply_reset_check("svc_reset");
            reset = 1'b0;
            bus.irq_in = '0;
            check("queue_empty_at_reset", exp_q.size(), 0);
            exp_q.delete();
            m_pend = 0;
            m_mask = 0;
            m_flag = 0;
            stop = 1'b1;
            return;
        end

        // Activity during SERVICE: new edges and mask writes do not touch the current vec
        d = $urandom_range(0, 2);
        repeat (d) begin
            inj = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : 0;
            nm  = m_mask;
            bus.irq_in = N_SRC'(inj);
            if ($urandom_range(0, 3) == 0) begin
                nm = $urandom_range(0, 15);
                bus.mask_wr = 1'b1;
                bus.mask_in = N_SRC'(nm);
            end
            tick();
            bus.irq_in  = '0;
            bus.mask_wr = 1'b0;
            m_pend = m_pend | inj;
            m_mask = nm;
            check("svc_vec_held", 32'(bus.intr_vec), v);
        end

        // End of interrupt
        bus.eoi = 1'b1;
        if (eligible()) push_expected();
        tick();
        bus.eoi = 1'b0;
        check("eoi_busy", 32'(bus.busy), 0);
        if (eligible()) begin
            wait_req(1, "eoi_req_latency", ok);
            if (!ok) stop = 1'b1;
        end
    endtask

    // Idle step: optional stray ack, optional mask write, optional edges, then service chain
    task automatic quiet_step(input bit do_mask, input int mask, input int edges, input bit stray_ack);
        bit ok;
        bit stop;
        if (stray_ack) begin
            bus.intr_ack = 1'b1;
            tick();
            bus.intr_ack = 1'b0;
            check("stray_ack_busy", 32'(bus.busy), 0);
        end
        bus.mask_wr = do_mask;
        bus.mask_in = N_SRC'(mask);
        bus.irq_in  = N_SRC'(edges);
        if (do_mask) m_mask = mask;
        m_pend = m_pend | edges;
        if (eligible()) push_expected();
        tick();
        bus.mask_wr = 1'b0;
        bus.irq_in  = '0;
        check("pending_latch", 32'(bus.pending), m_pend);
        check("req_not_yet", 32'(bus.intr_req), 0);
        if (eligible()) begin
            wait_req(1, "req_latency", ok);
            stop = !ok;
            while (!stop && eligible()) serve(stop);
        end else begin
            repeat (2) tick();
            check("idle_no_req", 32'(bus.intr_req), 0);
            check("idle_busy", 32'(bus.busy), 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.irq_in   = '0;
        bus.mask_wr  = 1'b0;
        bus.mask_in  = '0;
        bus.intr_ack = 1'b0;
        bus.eoi      = 1'b0;
        reset        = 1'b1;
        repeat (2) tick();
        apply_reset_check("reset");
        reset = 1'b0;
        tick();

        // Single source, simultaneous sources, masked source then unmask
        quiet_step(1'b1, 4'hF, 4'b0100, 1'b0);
        quiet_step(1'b0, 0, 4'b1010, 1'b1);
        quiet_step(1'b1, 4'b1110, 4'b0001, 1'b0);
        quiet_step(1'b1, 4'hF, 0, 1'b0);

        for (int r = 0; r < 200; r++) begin
            quiet_step(1'($urandom_range(0, 1)),
                       $urandom_range(0, 15),
                       ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15),
                       ($urandom_range(0, 3) == 0));
        end

        tick();
        check("final_queue_empty", exp_q.size(), 0);
        check("final_pending", 32'(bus.pending), m_pend);
        check("final_tflag", 32'(bus.timeout_flag), m_flag);
        check("final_busy", 32'(bus.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
